mem_write_buffer: RTL and testbench

Posted-write buffer between the MEM stage's cache/memory request port and the word-level SRAM controller port. Stores are accepted immediately into a small FIFO and drained to SRAM in the background, so the pipeline freezes only when the buffer is full or a load misses the buffer. Loads are forwarded from the youngest matching pending store; otherwise they are issued to SRAM with priority over the drain.

---
 rtl/mem_wbuf_pkg.sv | 22 ++
 rtl/wbuf_entry_array.sv | 81 ++++++++
 rtl/mem_write_buffer.sv | 149 ++++++++++++++
 tb/tb_mem_write_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wbuf_pkg.sv
// Shared types for the MEM-stage posted-write buffer.
// Entry layout and FSM encoding used by the top and the entry array.
package mem_wbuf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    READ,
    RESP
  } state_t;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int WORD_ADDR_W = DEF_ADDR_W - 2;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [DEF_DATA_W-1:0]  data;
  } entry_t;

endpackage

// File: rtl/wbuf_entry_array.sv
// Circular store FIFO with a parallel youngest-match lookup
// used to forward pending store data to loads.
module wbuf_entry_array
  import mem_wbuf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = WORD_ADDR_W,
  parameter int DW    = DEF_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [AW-1:0]    push_addr,
  input  logic [DW-1:0]    push_data,
  input  logic [AW-1:0]    lookup_addr,
  output logic [AW-1:0]    head_addr,
  output logic [DW-1:0]    head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             hit,
  output logic [DW-1:0]    hit_data
);

  typedef struct packed {
    logic [AW-1:0] word_addr;
    logic [DW-1:0] data;
  } slot_t;

  slot_t            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= '{word_addr: push_addr,
                     data:      push_data};
  end

  assign head_addr = mem[head].word_addr;
  assign head_data = mem[head].data;
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count &&
          mem[idx].word_addr == lookup_addr) begin
        hit      = 1'b1;
        hit_data = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between MEM stage and SRAM controller:
// stores drain in background, loads forward or bypass the drain.
module mem_write_buffer
  import mem_wbuf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              buffer_empty,
  output logic              sram_wr_en,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data,
  input  logic              sram_ready
);

  localparam int WAW   = ADDR_W - 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t             state;
  state_t             state_n;
  logic [WAW-1:0]     word_addr;
  logic [WAW-1:0]     head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [DATA_W-1:0]  hit_data;
  logic [DATA_W-1:0]  read_q;
  logic [DATA_W-1:0]  rdata_n;
  logic [DATA_W-1:0]  data_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [CNT_W-1:0]   count;
  logic               wr_n;
  logic               rd_n;
  logic               full;
  logic               empty;
  logic               hit;
  logic               miss;
  logic               push;
  logic               pop;
  logic               unused;

  assign word_addr = address[ADDR_W-1:2];
  assign unused    = ^{address[1:0], count};

  assign miss = rd_en & ~hit;
  assign push = wr_en & ~rd_en & ~full;

  wbuf_entry_array #(
    .DEPTH (DEPTH),
    .AW    (WAW),
    .DW    (DATA_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_addr   (word_addr),
    .push_data   (write_data),
    .lookup_addr (word_addr),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // Loads take precedence when both requests are raised.
  always_comb begin
    ready = 1'b1;
    if (rd_en)
      ready = hit | (state == RESP);
    else if (wr_en)
      ready = ~full;
  end

  assign read_data    = (rd_en && hit) ? hit_data : read_q;
  assign buffer_empty = empty && (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      sram_wr_en      <= 1'b0;
      sram_rd_en      <= 1'b0;
      sram_address    <= '0;
      sram_write_data <= '0;
      read_q          <= '0;
    end else begin
      state           <= state_n;
      sram_wr_en      <= wr_n;
      sram_rd_en      <= rd_n;
      sram_address    <= addr_n;
      sram_write_data <= data_n;
      read_q          <= rdata_n;
    end
  end

  // A waiting miss is checked before the next drain starts.
  always_comb begin
    state_n = state;
    wr_n    = sram_wr_en;
    rd_n    = sram_rd_en;
    addr_n  = sram_address;
    data_n  = sram_write_data;
    rdata_n = read_q;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss) begin
          state_n = READ;
          rd_n    = 1'b1;
          addr_n  = {word_addr, 2'b00};
        end else if (!empty) begin
          state_n = DRAIN;
          wr_n    = 1'b1;
          addr_n  = {head_addr, 2'b00};
          data_n  = head_data;
        end
      end
      DRAIN: begin
        if (sram_ready) begin
          state_n = IDLE;
          wr_n    = 1'b0;
          pop     = 1'b1;
        end
      end
      READ: begin
        if (sram_ready) begin
          state_n = RESP;
          rd_n    = 1'b0;
          rdata_n = sram_read_data;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: vector table for forwarding
// and stalls, plus sequences for drain, miss and wrap cases.
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        buffer_empty;
  logic        sram_wr_en;
  logic        sram_rd_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        sram_ready;

  always #5 clk = ~clk;

  mem_write_buffer #(
    .DEPTH  (4),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .ready           (ready),
    .buffer_empty    (buffer_empty),
    .sram_wr_en      (sram_wr_en),
    .sram_rd_en      (sram_rd_en),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready)
  );

  // SRAM model: completes a request after sram_lat waiting cycles
  int          lat_cnt;
  int          sram_lat;
  logic [31:0] sram_rdata;

  assign sram_ready = (sram_wr_en | sram_rd_en) &&
                      (lat_cnt >= sram_lat);
  assign sram_read_data = sram_rdata;

  always @(posedge clk or negedge rst) begin
    if (!rst)
      lat_cnt <= 0;
    else if ((sram_wr_en | sram_rd_en) && !sram_ready)
      lat_cnt <= lat_cnt + 1;
    else
      lat_cnt <= 0;
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t evq[$];

  always @(posedge clk) begin
    if (rst && sram_ready)
      evq.push_back('{sram_wr_en, sram_address,
                      sram_wr_en ? sram_write_data
                                 : sram_read_data});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic do_store(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          output int stalls);
    @(negedge clk);
    wr_en      = 1'b1;
    address    = a;
    write_data = d;
    #1;
    stalls = 0;
    while (!ready && stalls < 50) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    chk({tag, " accept"}, {31'b0, ready}, 32'd1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_load(input string tag,
                         input logic [31:0] a,
                         output int stalls,
                         output logic [31:0] d);
    @(negedge clk);
    rd_en   = 1'b1;
    address = a;
    #1;
    stalls = 0;
    while (!ready && stalls < 50) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    chk({tag, " done"}, {31'b0, ready}, 32'd1);
    d = read_data;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!buffer_empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " drained"}, {31'b0, buffer_empty}, 32'd1);
  endtask

  task automatic check_writes(input string tag,
                              input logic [31:0] base,
                              input logic [31:0] d0,
                              input int n);
    chk({tag, " nev"}, evq.size(), n);
    for (int i = 0; i < n && i < evq.size(); i++) begin
      chk($sformatf("%s ev%0d wr", tag, i),
          {31'b0, evq[i].is_wr}, 32'd1);
      chk($sformatf("%s ev%0d addr", tag, i),
          evq[i].addr, base + 32'(4 * i));
      chk($sformatf("%s ev%0d data", tag, i),
          evq[i].data, d0 + 32'(i));
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int          st;
    logic [31:0] d;

    vt[0]  = '{0, 0, 32'h000, 32'h00, 1, 0, 32'h00};
    vt[1]  = '{1, 0, 32'h404, 32'hAA, 1, 0, 32'h00};
    vt[2]  = '{1, 0, 32'h404, 32'hBB, 1, 0, 32'h00};
    vt[3]  = '{0, 1, 32'h405, 32'h00, 1, 1, 32'hBB};
    vt[4]  = '{1, 0, 32'h408, 32'hCC, 1, 0, 32'h00};
    vt[5]  = '{0, 1, 32'h408, 32'h00, 1, 1, 32'hCC};
    vt[6]  = '{0, 1, 32'h407, 32'h00, 1, 1, 32'hBB};
    vt[7]  = '{1, 0, 32'h40C, 32'hDD, 1, 0, 32'h00};
    vt[8]  = '{1, 0, 32'h410, 32'hEE, 0, 0, 32'h00};
    vt[9]  = '{0, 1, 32'h40E, 32'h00, 1, 1, 32'hDD};
    vt[10] = '{1, 1, 32'h404, 32'h99, 1, 1, 32'hBB};
    vt[11] = '{0, 0, 32'h000, 32'h00, 1, 0, 32'h00};

    rst        = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = '0;
    write_data = '0;
    sram_lat   = 0;
    sram_rdata = '0;
    #1;
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst empty", {31'b0, buffer_empty}, 32'd1);
    chk("rst sram_wr", {31'b0, sram_wr_en}, 32'd0);
    chk("rst sram_rd", {31'b0, sram_rd_en}, 32'd0);
    chk("rst rdata", read_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // reset in the middle of a drain
    sram_lat = 20;
    do_store("t1 s0", 32'h800, 32'h77, st);
    do_store("t1 s1", 32'h804, 32'h88, st);
    st = 0;
    while (!sram_wr_en && st < 20) begin
      @(negedge clk);
      st++;
    end
    chk("t1 draining", {31'b0, sram_wr_en}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t1 sram_wr", {31'b0, sram_wr_en}, 32'd0);
    chk("t1 sram_rd", {31'b0, sram_rd_en}, 32'd0);
    chk("t1 sram_addr", sram_address, 32'd0);
    chk("t1 sram_wdata", sram_write_data, 32'd0);
    chk("t1 rdata", read_data, 32'd0);
    chk("t1 empty", {31'b0, buffer_empty}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    evq.delete();
    sram_lat   = 0;
    sram_rdata = 32'h5555;
    do_load("t1 ld", 32'h800, st, d);
    chk("t1 ld stalls", st, 2);
    chk("t1 ld data", d, 32'h5555);
    chk("t1 nev", evq.size(), 1);
    if (evq.size() == 1) begin
      chk("t1 ev rd", {31'b0, evq[0].is_wr}, 32'd0);
      chk("t1 ev addr", evq[0].addr, 32'h800);
    end

    // vector table: forwarding, full stall, rd priority
    sram_lat = 1000;
    evq.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      wr_en      = vt[k].wr;
      rd_en      = vt[k].rd;
      address    = vt[k].addr;
      write_data = vt[k].wdata;
      #1;
      chk($sformatf("vec%0d ready", k),
          {31'b0, ready}, {31'b0, vt[k].exp_ready});
      if (vt[k].chk_data)
        chk($sformatf("vec%0d rdata", k),
            read_data, vt[k].exp_data);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    sram_lat = 1;
    wait_empty("tbl");
    chk("tbl nev", evq.size(), 4);
    if (evq.size() == 4) begin
      chk("tbl e0", evq[0].data, 32'hAA);
      chk("tbl e1", evq[1].data, 32'hBB);
      chk("tbl e2", evq[2].data, 32'hCC);
      chk("tbl e2a", evq[2].addr, 32'h408);
      chk("tbl e3", evq[3].data, 32'hDD);
      chk("tbl e3a", evq[3].addr, 32'h40C);
      chk("tbl e1wr", {31'b0, evq[1].is_wr}, 32'd1);
    end

    // load miss on an empty buffer
    evq.delete();
    sram_lat   = 0;
    sram_rdata = 32'h1234;
    do_load("t4", 32'h500, st, d);
    chk("t4 stalls", st, 2);
    chk("t4 data", d, 32'h1234);
    if (evq.size() == 1)
      chk("t4 addr", evq[0].addr, 32'h500);
    else
      chk("t4 nev", evq.size(), 1);

    // burst of five stores into a four-deep buffer
    evq.delete();
    sram_lat = 3;
    for (int i = 0; i < 5; i++) begin
      do_store($sformatf("t2 s%0d", i), 32'h400 + 32'(4 * i),
               32'(i + 1), st);
      chk($sformatf("t2 s%0d stalls", i), st, (i == 4) ? 2 : 0);
    end
    wait_empty("t2");
    check_writes("t2", 32'h400, 32'd1, 5);

    // load miss arriving during a drain
    evq.delete();
    sram_lat = 2;
    do_store("t5 s0", 32'h400, 32'h11, st);
    do_store("t5 s1", 32'h404, 32'h22, st);
    chk("t5 draining", {31'b0, sram_wr_en}, 32'd1);
    chk("t5 drain addr", sram_address, 32'h400);
    sram_rdata = 32'hCAFE0600;
    do_load("t5 ld", 32'h600, st, d);
    chk("t5 stalls", st, 7);
    chk("t5 data", d, 32'hCAFE0600);
    wait_empty("t5");
    chk("t5 nev", evq.size(), 3);
    if (evq.size() == 3) begin
      chk("t5 e0", {evq[0].is_wr, evq[0].addr[30:0]},
          {1'b1, 31'h400});
      chk("t5 e1", {evq[1].is_wr, evq[1].addr[30:0]},
          {1'b0, 31'h600});
      chk("t5 e2", {evq[2].is_wr, evq[2].addr[30:0]},
          {1'b1, 31'h404});
      chk("t5 e2d", evq[2].data, 32'h22);
    end

    // full buffer with both pointers wrapping past slot 3
    evq.delete();
    sram_lat = 3;
    for (int i = 0; i < 5; i++) begin
      do_store($sformatf("t6 s%0d", i), 32'h700 + 32'(4 * i),
               32'h61 + 32'(i), st);
      chk($sformatf("t6 s%0d stalls", i), st, (i == 4) ? 2 : 0);
    end
    chk("t6 count", 32'(dut.u_array.count), 32'd4);
    wait_empty("t6");
    check_writes("t6", 32'h700, 32'h61, 5);

    // push and pop on the same edge
    evq.delete();
    sram_lat = 0;
    for (int i = 0; i < 4; i++) begin
      do_store($sformatf("t7 s%0d", i), 32'h900 + 32'(4 * i),
               32'h91 + 32'(i), st);
      chk($sformatf("t7 s%0d stalls", i), st, 0);
    end
    chk("t7 count", 32'(dut.u_array.count), 32'd3);
    wait_empty("t7");
    check_writes("t7", 32'h900, 32'h91, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
